// File: rtl/fifo_tcp_serializer_if.sv
`default_nettype none
// ==== fifo_tcp_serializer_if : upstream write stream, TCP byte stream and debug status ====
// ==== rev 1.0 ====
interface fifo_tcp_serializer_if #(
  parameter int AW = 4
);
  logic          CLEAR;
  logic          FIFO_WRITE;
  logic [31:0]   FIFO_DATA;
  logic          FIFO_FULL;
  logic [7:0]    TCP_TX_DATA;
  logic          TCP_TX_VALID;
  logic          TCP_TX_READY;
  logic [AW:0]   WORD_COUNT;
  logic          OVERFLOW;

  modport master (
    output CLEAR, FIFO_WRITE, FIFO_DATA, TCP_TX_READY,
    input  FIFO_FULL, TCP_TX_DATA, TCP_TX_VALID, WORD_COUNT, OVERFLOW
  );

  modport slave (
    input  CLEAR, FIFO_WRITE, FIFO_DATA, TCP_TX_READY,
    output FIFO_FULL, TCP_TX_DATA, TCP_TX_VALID, WORD_COUNT, OVERFLOW
  );
endinterface
`default_nettype wire

// File: rtl/fifo_tcp_serializer.sv
`default_nettype none
// ==== fifo_tcp_serializer : 32-bit word FIFO drained as little-endian bytes on valid/ready ====
// ==== rev 1.0 ====
module fifo_tcp_serializer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic              BUS_CLK,
  input  wire logic              RESET_N,
  fifo_tcp_serializer_if.slave   bus
);

  localparam logic [AW:0] c_FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_valid;
  logic [7:0]    r_data;
  logic [1:0]    r_idx;
  logic [31:0]   r_hold;
  state_t        r_state;

  logic          w_full;
  logic          w_push;
  logic          w_hs;
  logic          w_pop;
  logic [31:0]   w_rd;
  logic [1:0]    w_idx_nx;

  // Fullness uses the registered count only, so a same-edge pop never admits a push.
  assign w_full   = (r_count == c_FULL_CNT);
  assign w_push   = bus.FIFO_WRITE && !w_full && !bus.CLEAR;
  assign w_hs     = r_valid && bus.TCP_TX_READY;
  assign w_pop    = (r_count != '0) &&
                    ((r_state == S_IDLE) || (w_hs && (r_idx == 2'd3)));
  assign w_rd     = r_mem[r_rptr];
  assign w_idx_nx = r_idx + 2'd1;

  always_ff @(posedge BUS_CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= bus.FIFO_DATA;
    end
  end

  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_idx      <= '0;
      r_hold     <= '0;
      r_state    <= S_IDLE;
    end else if (bus.CLEAR) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
      r_idx      <= '0;
      r_state    <= S_IDLE;
    end else begin
      if (bus.FIFO_WRITE && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A pop always loads HOLD and presents byte0 on the following cycle.
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_hold  <= w_rd;
            r_data  <= w_rd[7:0];
            r_idx   <= 2'd0;
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_hs) begin
            if (r_idx != 2'd3) begin
              r_idx  <= w_idx_nx;
              r_data <= r_hold[{w_idx_nx, 3'b000} +: 8];
            end else if (w_pop) begin
              r_hold <= w_rd;
              r_data <= w_rd[7:0];
              r_idx  <= 2'd0;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.FIFO_FULL    = w_full;
  assign bus.TCP_TX_DATA  = r_data;
  assign bus.TCP_TX_VALID = r_valid;
  assign bus.WORD_COUNT   = r_count;
  assign bus.OVERFLOW     = r_overflow;

endmodule
`default_nettype wire
